// File: rtl/afp_pack_stream.sv
// ---------------------------------------------------------------------------
// afp_pack_stream
//
// Output-side encoder for the 4-bit AFP datapath. It takes unpacked product
// fields (sign, significand product, offset sum), then normalizes, rounds and
// saturates them into the 4-bit AFP code {s, o[1:0], m}. The codes are packed
// eight to a 32-bit word and streamed out over valid/ready.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    product handshake
//   in_s, in_pm, in_po     product sign, significand product (0..9), offset sum
//   in_last                final product of a block; flushes a partial word
//   out_valid / out_ready  packed word handshake
//   out_word               lane k in bits [4k+3:4k], lane 0 is the oldest code
//   out_count              number of valid lanes, 1..8
//   out_last               word contains an in_last product
//   flag_ovf, flag_unf     sticky overflow / underflow flags
//
// Build option:
//   AFP_PACK_FLAGS_EN  when defined, the sticky flags are implemented; when
//                      undefined, both flags are tied to 0.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holds valid and its payload steady
// until the transfer; out_word/out_count/out_last never change while
// out_valid && !out_ready.
// ---------------------------------------------------------------------------
module afp_pack_stream (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_s,
    input  logic [3:0]  in_pm,
    input  logic [3:0]  in_po,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_count,
    output logic        out_last,
    output logic        flag_ovf,
    output logic        flag_unf
);

    // ------------------------------------------------------------------
    // Stage 1 combinational encode
    // ------------------------------------------------------------------
    logic [1:0]        lead;
    logic [1:0]        sig_raw;
    logic              rnd_up;
    logic signed [5:0] o_raw;
    logic signed [5:0] o_rnd;
    logic [1:0]        sig_rnd;
    logic [3:0]        enc_code;
    logic              enc_ovf;
    logic              enc_unf;

    always_comb begin
        lead = 2'd0;
        casez (in_pm)
            4'b1???: lead = 2'd3;
            4'b01??: lead = 2'd2;
            4'b001?: lead = 2'd1;
            default: lead = 2'd0;
        endcase

        // Two significant bits starting at the leading one; a lone 1 is {1,0}.
        sig_raw = 2'b10;
        case (lead)
            2'd3:    sig_raw = in_pm[3:2];
            2'd2:    sig_raw = in_pm[2:1];
            2'd1:    sig_raw = in_pm[1:0];
            default: sig_raw = 2'b10;
        endcase

        // Round to nearest even: guard is the first discarded bit, sticky the
        // rest, and sig_raw[0] breaks an exact tie.
        rnd_up = 1'b0;
        case (lead)
            2'd3:    rnd_up = in_pm[1] && (in_pm[0] || in_pm[2]);
            2'd2:    rnd_up = in_pm[0] && in_pm[1];
            default: rnd_up = 1'b0;
        endcase

        o_raw = $signed({2'b00, in_po}) + 6'sd2 - $signed({4'b0000, lead});

        sig_rnd = sig_raw;
        o_rnd   = o_raw;
        if (rnd_up) begin
            if (sig_raw == 2'b11) begin
                // 3 + 1 = 4 = {1,0} one binade up
                sig_rnd = 2'b10;
                o_rnd   = o_raw - 6'sd1;
            end else begin
                sig_rnd = 2'b11;
            end
        end

        // Zero keeps the sign: {s,11,0}.
        enc_code = {in_s, 3'b110};
        enc_ovf  = 1'b0;
        enc_unf  = 1'b0;
        if (in_pm == 4'd0) begin
            enc_code = {in_s, 3'b110};
        end else if (o_rnd[5]) begin
            enc_code = {in_s, 3'b001};
            enc_ovf  = 1'b1;
        end else if (o_rnd <= 6'sd2) begin
            enc_code = {in_s, o_rnd[1:0], sig_rnd[0]};
        end else if (o_rnd == 6'sd3) begin
            // Denormal range: 2 is exactly {s,11,1}; 3 is a tie that goes to
            // the even neighbour 0.5 = {s,10,0}.
            enc_code = sig_rnd[0] ? {in_s, 3'b100} : {in_s, 3'b111};
        end else if (o_rnd == 6'sd4) begin
            if (sig_rnd[0]) begin
                enc_code = {in_s, 3'b111};
            end else begin
                enc_code = {in_s, 3'b110};
                enc_unf  = 1'b1;
            end
        end else begin
            enc_code = {in_s, 3'b110};
            enc_unf  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic [3:0] s1_code;
    logic       s1_last;
    logic       s1_transfer;
    logic       in_accept;
    logic       out_handoff;

    assign out_handoff = out_valid && out_ready;
    // Stage 1 may only drain when the output register is free or emptying.
    assign s1_transfer = s1_valid && !(out_valid && !out_ready);
    assign in_ready    = !s1_valid || s1_transfer;
    assign in_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= 4'd0;
            s1_last  <= 1'b0;
        end else if (in_accept) begin
            s1_valid <= 1'b1;
            s1_code  <= enc_code;
            s1_last  <= in_last;
        end else if (s1_transfer) begin
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 pack: acc_q collects the word under construction (unused
    // lanes stay 0); out_word holds the presented word so a new word can
    // start in lane 0 while the previous one is still being offered.
    // ------------------------------------------------------------------
    logic [2:0]  lane_q;
    logic [31:0] acc_q;
    logic [31:0] acc_next;
    logic        word_done;

    assign acc_next  = acc_q | ({28'd0, s1_code} << {lane_q, 2'b00});
    assign word_done = (lane_q == 3'd7) || s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= 3'd0;
            acc_q     <= 32'd0;
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_count <= 4'd0;
            out_last  <= 1'b0;
        end else begin
            if (out_handoff) begin
                out_valid <= 1'b0;
            end
            if (s1_transfer) begin
                if (word_done) begin
                    out_valid <= 1'b1;
                    out_word  <= acc_next;
                    out_count <= {1'b0, lane_q} + 4'd1;
                    out_last  <= s1_last;
                    acc_q     <= 32'd0;
                    lane_q    <= 3'd0;
                end else begin
                    acc_q     <= acc_next;
                    lane_q    <= lane_q + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------
`ifdef AFP_PACK_FLAGS_EN
    logic s1_ovf;
    logic s1_unf;
    logic flag_ovf_q;
    logic flag_unf_q;
    logic flag_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ovf <= 1'b0;
            s1_unf <= 1'b0;
        end else if (in_accept) begin
            s1_ovf <= enc_ovf;
            s1_unf <= enc_unf;
        end
    end

    // Handing off the block's last word ends the block; an event arriving
    // on that same edge belongs to the next block and is kept.
    assign flag_clr = out_handoff && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
        end else begin
            flag_ovf_q <= (flag_ovf_q && !flag_clr) || (s1_transfer && s1_ovf);
            flag_unf_q <= (flag_unf_q && !flag_clr) || (s1_transfer && s1_unf);
        end
    end

    assign flag_ovf = flag_ovf_q;
    assign flag_unf = flag_unf_q;
`else
    logic unused_flag_events;
    assign unused_flag_events = enc_ovf ^ enc_unf;
    assign flag_ovf = 1'b0;
    assign flag_unf = 1'b0;
`endif

endmodule

// File: tb/tb_afp_pack_stream.sv
// ---------------------------------------------------------------------------
// tb_afp_pack_stream
//
// Self-checking bench for afp_pack_stream. A value-level reference model
// (exact product value, two-significant-bit rounding, nearest-even pick on
// the table of representable AFP magnitudes) predicts every code; packed
// words are predicted with a code queue and checked by a handoff monitor.
// Build option AFP_PACK_FLAGS_EN must match the one used for the RTL.
// ---------------------------------------------------------------------------
module tb_afp_pack_stream;

`ifdef AFP_PACK_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [3:0]  in_pm;
  logic [3:0]  in_po;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_count;
  logic        out_last;
  logic        flag_ovf;
  logic        flag_unf;

  afp_pack_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_pm     (in_pm),
    .in_po     (in_po),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_last  (out_last),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {unf, ovf, code}. Values are in units of 1/256.
  function automatic logic [5:0] ref_encode(input logic s, input logic [3:0] pm, input logic [3:0] po);
    int v, p, sh, q, rem, half, r, bi, bd, d;
    int gv [8];
    logic [2:0] gc [8];
    logic [2:0] pick;
    gv = '{0, 64, 128, 192, 256, 384, 512, 768};
    gc = '{3'b110, 3'b111, 3'b100, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001};
    if (pm == 4'd0) return {2'b00, s, 3'b110};
    v = int'(pm) << (7 - int'(po));
    p = 0;
    for (int i = 0; i < 16; i++) if (((v >> i) & 1) == 1) p = i;
    if (p <= 1) begin
      r = v;
    end else begin
      sh   = p - 1;
      q    = v >> sh;
      rem  = v - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      r = q << sh;
    end
    if (r > 768) return {2'b01, s, 3'b001};
    bi = 0;
    bd = 1 << 30;
    for (int i = 0; i < 8; i++) begin
      d = (r > gv[i]) ? r - gv[i] : gv[i] - r;
      pick = gc[i];
      if (d < bd || (d == bd && pick[0] == 1'b0)) begin
        bd = d;
        bi = i;
      end
    end
    return {(bi == 0), 1'b0, s, gc[bi]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  logic [6:0]  meta_q [$];   // {unf, ovf, last, count}
  logic [3:0]  lane_codes [$];
  logic        blk_ovf, blk_unf;

  task automatic model_clear();
    exp_q.delete();
    meta_q.delete();
    lane_codes.delete();
    blk_ovf = 1'b0;
    blk_unf = 1'b0;
  endtask

  task automatic model_accept(input logic s, input logic [3:0] pm, input logic [3:0] po, input logic last);
    logic [5:0]  r;
    logic [31:0] w;
    int          n;
    r = ref_encode(s, pm, po);
    lane_codes.push_back(r[3:0]);
    blk_ovf = blk_ovf | r[4];
    blk_unf = blk_unf | r[5];
    if (lane_codes.size() == 8 || last) begin
      w = 32'd0;
      n = lane_codes.size();
      for (int k = 0; k < n; k++) w[4*k +: 4] = lane_codes[k];
      exp_q.push_back(w);
      meta_q.push_back({blk_unf, blk_ovf, last, 4'(n)});
      lane_codes.delete();
      if (last) begin
        blk_ovf = 1'b0;
        blk_unf = 1'b0;
      end
    end
  endtask

  // Monitor: handoffs are compared against the queue, accepts feed the model.
  logic [31:0] mon_w;
  logic [6:0]  mon_m;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          mon_w = exp_q.pop_front();
          mon_m = meta_q.pop_front();
          check("word", out_word, mon_w);
          check("count", {28'd0, out_count}, {28'd0, mon_m[3:0]});
          check("last", {31'd0, out_last}, {31'd0, mon_m[4]});
          check("flag_ovf", {31'd0, flag_ovf}, {31'd0, FLAGS_ON & mon_m[5]});
          check("flag_unf", {31'd0, flag_unf}, {31'd0, FLAGS_ON & mon_m[6]});
        end
      end
      if (in_valid && in_ready) model_accept(in_s, in_pm, in_po, in_last);
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_rdy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
  end

  task automatic send(input logic s, input logic [3:0] pm, input logic [3:0] po, input logic last);
    in_valid = 1'b1;
    in_s     = s;
    in_pm    = pm;
    in_po    = po;
    in_last  = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_word"}, out_word, 32'd0);
    check({tag, "_out_count"}, {28'd0, out_count}, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_flag_ovf"}, {31'd0, flag_ovf}, 32'd0);
    check({tag, "_flag_unf"}, {31'd0, flag_unf}, 32'd0);
  endtask

  // Single product as its own block; the word is held stalled for inspection.
  task automatic directed(input logic s, input logic [3:0] pm, input logic [3:0] po,
                          input logic [3:0] code, input logic eo, input logic eu);
    out_ready = 1'b0;
    send(s, pm, po, 1'b1);
    for (int t = 0; t < 20 && !out_valid; t++) tick(1);
    check("dir_valid", {31'd0, out_valid}, 32'd1);
    check("dir_code", {28'd0, out_word[3:0]}, {28'd0, code});
    check("dir_count", {28'd0, out_count}, 32'd1);
    check("dir_ovf", {31'd0, flag_ovf}, {31'd0, FLAGS_ON & eo});
    check("dir_unf", {31'd0, flag_unf}, {31'd0, FLAGS_ON & eu});
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] held_w;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_s      = 1'b0;
    in_pm     = 4'd0;
    in_po     = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick(1);

    // Encoding corner cases
    directed(1'b0, 4'b1001, 4'd2, 4'b0010, 1'b0, 1'b0);
    directed(1'b0, 4'b0111, 4'd1, 4'b0000, 1'b0, 1'b0);
    directed(1'b1, 4'b1001, 4'd0, 4'b1001, 1'b1, 1'b0);
    directed(1'b0, 4'b0100, 4'd5, 4'b0110, 1'b0, 1'b1);
    directed(1'b0, 4'b0011, 4'd2, 4'b0100, 1'b0, 1'b0);
    directed(1'b1, 4'b0000, 4'd3, 4'b1110, 1'b0, 1'b0);
    directed(1'b0, 4'b1001, 4'd5, 4'b0110, 1'b0, 1'b1);

    // Full word streaming, then a 9th code starting the next word
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), 4'($urandom_range(1, 9)), 4'($urandom_range(0, 3)), 1'b0);
    check("stream_not_early", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("stream_latency", {31'd0, out_valid}, 32'd1);
    check("stream_count", {28'd0, out_count}, 32'd8);
    send(1'b0, 4'b1001, 4'd2, 1'b1);
    tick(4);
    check("stream_drained", exp_q.size(), 32'd0);

    // Partial word under backpressure, then reset mid-stall
    out_ready = 1'b0;
    send(1'b0, 4'd5, 4'd1, 1'b0);
    send(1'b1, 4'd9, 4'd3, 1'b0);
    send(1'b0, 4'd2, 4'd0, 1'b1);
    tick(1);
    held_w = out_word;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_word", out_word, exp_q[0]);
      check("stall_stable", out_word, held_w);
      check("stall_upper", {12'd0, out_word[31:12]}, 32'd0);
      check("stall_count", {28'd0, out_count}, 32'd3);
      check("stall_last", {31'd0, out_last}, 32'd1);
      tick(1);
    end
    check("stall_ready_free", {31'd0, in_ready}, 32'd1);
    send(1'b0, 4'd6, 4'd2, 1'b0);
    check("stall_ready_drop", {31'd0, in_ready}, 32'd0);
    check("stall_word_kept", out_word, held_w);
    rst_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)),
           ($urandom_range(0, 5) == 0));
    end
    send(1'b0, 4'd3, 4'd1, 1'b1);
    tick(1);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && (exp_q.size() != 0 || out_valid); t++) tick(1);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_lanes_empty", lane_codes.size(), 32'd0);
    check("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
